// File: rtl/data_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single-port data bus (Read/Write/Done handshake).
// Define DATA_BUS_ARB_TIMEOUT_EN to abort stalled grants after TIMEOUT_CYCLES with an ArbErr pulse.
module data_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        Clock,
    input  logic        Reset,

    input  logic        M0ReadData,
    input  logic        M0WriteData,
    input  logic [15:0] M0Addr,
    input  logic [15:0] M0BusIn,
    output logic [15:0] M0BusOut,
    output logic        M0Done,

    input  logic        M1ReadData,
    input  logic        M1WriteData,
    input  logic [15:0] M1Addr,
    input  logic [15:0] M1BusIn,
    output logic [15:0] M1BusOut,
    output logic        M1Done,

    output logic        ReadData,
    output logic        WriteData,
    output logic [15:0] DataAddr,
    output logic [15:0] BusIn,
    input  logic [15:0] BusOut,
    input  logic        DataDone,

    output logic        ArbErr,
    output logic [1:0]  DbgState
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        m0_req;
    logic        m1_req;
    logic        gnt_active;
    logic        gnt_rd;
    logic        gnt_wr;
    logic [15:0] gnt_addr;
    logic [15:0] gnt_wdata;
    logic        timeout_hit;

    assign m0_req     = M0ReadData | M0WriteData;
    assign m1_req     = M1ReadData | M1WriteData;
    assign gnt_active = (state_q == ST_GRANT0) || (state_q == ST_GRANT1);

    // Granted master's signals; everything reads as zero outside GRANTn.
    always_comb begin
        gnt_rd    = 1'b0;
        gnt_wr    = 1'b0;
        gnt_addr  = 16'h0000;
        gnt_wdata = 16'h0000;
        case (state_q)
            ST_GRANT0: begin
                gnt_rd    = M0ReadData;
                gnt_wr    = M0WriteData;
                gnt_addr  = M0Addr;
                gnt_wdata = M0BusIn;
            end
            ST_GRANT1: begin
                gnt_rd    = M1ReadData;
                gnt_wr    = M1WriteData;
                gnt_addr  = M1Addr;
                gnt_wdata = M1BusIn;
            end
            default: begin
                gnt_rd    = 1'b0;
                gnt_wr    = 1'b0;
                gnt_addr  = 16'h0000;
                gnt_wdata = 16'h0000;
            end
        endcase
    end

`ifdef DATA_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside GRANTn, so it starts from zero on every grant entry.
    always_comb begin
        cnt_d = '0;
        if (gnt_active) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign timeout_hit = gnt_active && !DataDone &&
                         (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic timeout_unused;

    assign timeout_hit    = 1'b0;
    assign timeout_unused = (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rdata_d      = rdata_q;
        err_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // On a tie the master that did not win last time gets the bus.
                if (m0_req && (!m1_req || last_grant_q)) begin
                    state_d      = ST_GRANT0;
                    last_grant_d = 1'b0;
                end else if (m1_req) begin
                    state_d      = ST_GRANT1;
                    last_grant_d = 1'b1;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (!(gnt_rd || gnt_wr)) begin
                    state_d = ST_IDLE;
                end else if (DataDone) begin
                    rdata_d = BusOut;
                    state_d = ST_RESP;
                end else if (timeout_hit) begin
                    rdata_d = 16'hDEAD;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            rdata_q      <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
        end
    end

    // Write wins when a master raises both strobes.
    assign ReadData  = gnt_rd & ~gnt_wr;
    assign WriteData = gnt_wr;
    assign DataAddr  = gnt_addr;
    assign BusIn     = gnt_wdata;

    assign M0Done    = (state_q == ST_RESP) && !last_grant_q;
    assign M1Done    = (state_q == ST_RESP) &&  last_grant_q;
    assign M0BusOut  = rdata_q;
    assign M1BusOut  = rdata_q;
    assign ArbErr    = err_q;
    assign DbgState  = state_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a small bus model: IO switches/LEDs plus registered-done memory.
module tb_data_bus_arbiter;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT0 = 2'd1;
    localparam logic [1:0] S_GRANT1 = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_rd = 1'b0, m0_wr = 1'b0, m1_rd = 1'b0, m1_wr = 1'b0;
    logic [15:0] m0_addr = 16'h0, m0_wdata = 16'h0, m1_addr = 16'h0, m1_wdata = 16'h0;
    logic [15:0] m0_rdata, m1_rdata;
    logic        m0_done, m1_done;
    logic        bus_rd, bus_wr;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_done, arb_err;
    logic [1:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    // Bus model
    logic [15:0] mem [0:255];
    logic [9:0]  sw = 10'h2A5;
    logic [9:0]  ledr;
    logic        md_q;
    logic        force_done0 = 1'b0;
    logic        arb_seen = 1'b0;
    logic        is_io;
    logic        model_done;

    assign is_io      = (bus_addr[15:12] == 4'h2);
    assign bus_rdata  = (bus_addr == 16'h2100) ? {6'b0, sw} : mem[bus_addr[7:0]];
    assign model_done = is_io ? (bus_rd | bus_wr) : md_q;
    assign bus_done   = force_done0 ? 1'b0 : model_done;

    always @(posedge clk) begin
        if (rst) md_q <= 1'b0;
        else     md_q <= (bus_rd | bus_wr) && !is_io && !md_q;
        if (bus_wr && !is_io) mem[bus_addr[7:0]] <= bus_wdata;
        if (bus_wr && bus_addr == 16'h2200) ledr <= bus_wdata[9:0];
        if (arb_err) arb_seen <= 1'b1;
    end

    always #5 clk = ~clk;

    data_bus_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .Clock(clk), .Reset(rst),
        .M0ReadData(m0_rd), .M0WriteData(m0_wr), .M0Addr(m0_addr), .M0BusIn(m0_wdata),
        .M0BusOut(m0_rdata), .M0Done(m0_done),
        .M1ReadData(m1_rd), .M1WriteData(m1_wr), .M1Addr(m1_addr), .M1BusIn(m1_wdata),
        .M1BusOut(m1_rdata), .M1Done(m1_done),
        .ReadData(bus_rd), .WriteData(bus_wr), .DataAddr(bus_addr), .BusIn(bus_wdata),
        .BusOut(bus_rdata), .DataDone(bus_done),
        .ArbErr(arb_err), .DbgState(dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one transaction and waits (bounded) for that master's Done; lat = -1 on expiry.
    task automatic run_txn(input int m, input logic wr, input logic [15:0] addr,
                           input logic [15:0] wdata, output int lat,
                           output logic [15:0] rd, output logic other);
        lat = -1;
        rd = 16'h0;
        other = 1'b0;
        if (m == 0) begin
            m0_rd = ~wr; m0_wr = wr; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_rd = ~wr; m1_wr = wr; m1_addr = addr; m1_wdata = wdata;
        end
        for (int i = 1; i <= 20; i++) begin
            tick();
            if ((m == 0) ? m1_done : m0_done) other = 1'b1;
            if ((m == 0) ? m0_done : m1_done) begin
                lat = i + 1;
                rd = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        m0_rd = 1'b0; m0_wr = 1'b0; m1_rd = 1'b0; m1_wr = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [15:0] rd;
        logic        other;
        int          n_done;
        logic [0:0]  seq [0:7];
        logic        both_seen;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
        chk("rst_strobes", {30'b0, bus_rd, bus_wr}, 32'h0);
        chk("rst_addr_data", {bus_addr, bus_wdata}, 32'h0);
        chk("rst_done", {30'b0, m0_done, m1_done}, 32'h0);
        chk("rst_busout", {m0_rdata, m1_rdata}, 32'h0);
        chk("rst_arberr", {31'b0, arb_err}, 32'h0);
        rst = 1'b0;

        // M0 reads IO switches: combinational done, 3-cycle latency
        run_txn(0, 1'b0, 16'h2100, 16'h0, lat, rd, other);
        chk("io_rd_latency", lat, 3);
        chk("io_rd_data", {16'b0, rd}, 32'h02A5);
        chk("io_rd_m1done", {31'b0, other}, 32'h0);
        chk("io_rd_back_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});

        // M1 writes memory, check forwarding during GRANT1
        m1_wr = 1'b1; m1_addr = 16'h0010; m1_wdata = 16'h1234;
        tick();
        chk("wr_state", {30'b0, dbg_state}, {30'b0, S_GRANT1});
        chk("wr_strobes", {30'b0, bus_rd, bus_wr}, 32'h1);
        chk("wr_addr", {16'b0, bus_addr}, 32'h0010);
        chk("wr_data", {16'b0, bus_wdata}, 32'h1234);
        tick();
        tick();
        chk("wr_done", {30'b0, m0_done, m1_done}, 32'h1);
        m1_wr = 1'b0;
        tick();

        // M1 reads back: registered done, 4-cycle latency
        run_txn(1, 1'b0, 16'h0010, 16'h0, lat, rd, other);
        chk("mem_rd_latency", lat, 4);
        chk("mem_rd_data", {16'b0, rd}, 32'h1234);
        chk("mem_rd_m0done", {31'b0, other}, 32'h0);

        // Continuous contention after reset: grants alternate starting with M0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_rd = 1'b1; m0_addr = 16'h2100;
        m1_rd = 1'b1; m1_addr = 16'h0010;
        n_done = 0;
        both_seen = 1'b0;
        for (int i = 0; i < 60 && n_done < 8; i++) begin
            tick();
            if (m0_done && m1_done) both_seen = 1'b1;
            if (m0_done || m1_done) begin
                seq[n_done] = m1_done;
                n_done++;
            end
        end
        m0_rd = 1'b0; m1_rd = 1'b0;
        tick();
        tick();
        chk("rr_count", n_done, 8);
        chk("rr_both_done", {31'b0, both_seen}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            if (i < n_done) chk($sformatf("rr_order_%0d", i), {31'b0, seq[i]}, i % 2);
        end

        // Both strobes high: write wins, LEDR gets the data
        m0_rd = 1'b1; m0_wr = 1'b1; m0_addr = 16'h2200; m0_wdata = 16'h0055;
        tick();
        chk("both_strobes", {30'b0, bus_rd, bus_wr}, 32'h1);
        tick();
        chk("both_done", {30'b0, m0_done, m1_done}, 32'h2);
        m0_rd = 1'b0; m0_wr = 1'b0;
        tick();
        chk("ledr_value", {22'b0, ledr}, 32'h055);

        // Reset during GRANT0 of a memory read
        m0_rd = 1'b1; m0_addr = 16'h0010;
        tick();
        chk("rstmid_grant", {30'b0, dbg_state}, {30'b0, S_GRANT0});
        rst = 1'b1;
        tick();
        chk("rstmid_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
        chk("rstmid_strobes", {30'b0, bus_rd, bus_wr}, 32'h0);
        chk("rstmid_nodone", {30'b0, m0_done, m1_done}, 32'h0);
        rst = 1'b0;
        m1_rd = 1'b1; m1_addr = 16'h0010;
        tick();
        chk("rstmid_tie_m0", {30'b0, dbg_state}, {30'b0, S_GRANT0});

        // M0 drops its strobe mid-grant: back to IDLE, no Done
        m0_rd = 1'b0; m1_rd = 1'b0;
        tick();
        chk("abandon_idle", {30'b0, dbg_state}, {30'b0, S_IDLE});
        chk("abandon_nodone", {30'b0, m0_done, m1_done}, 32'h0);
        tick();

`ifdef DATA_BUS_ARB_TIMEOUT_EN
        // Stalled bus: abort after 4 grant cycles
        force_done0 = 1'b1;
        m0_rd = 1'b1; m0_addr = 16'h0010;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("to_grant_%0d", i), {29'b0, arb_err, dbg_state}, {29'b0, 1'b0, S_GRANT0});
        end
        tick();
        chk("to_arberr", {31'b0, arb_err}, 32'h1);
        chk("to_done", {30'b0, m0_done, m1_done}, 32'h2);
        chk("to_rdata", {16'b0, m0_rdata}, 32'hDEAD);
        m0_rd = 1'b0;
        force_done0 = 1'b0;
        tick();
        chk("to_arberr_pulse", {31'b0, arb_err}, 32'h0);
`else
        chk("no_arberr_ever", {31'b0, arb_seen}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-master arbiter that shares the single-port data bus (memory, on-chip FP unit, IO devices) between the pipeline's data port (master 0) and a second requester such as a DMA or debug port (master 1). It accepts one transaction at a time and grants the bus round-robin. It forwards the granted master's strobes, address and write data to the bus, and returns the completion and read data only to that master. It sits between the requesters and the bus module, and uses the bus's existing Read/Write/Done handshake unchanged on both sides.

## Interface
- TIMEOUT_CYCLES, 64: grant cycles allowed before abort (only with timeout feature).
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high.
- M0ReadData, M0WriteData  input  1 each  master 0 strobes; held until M0Done.
- M0Addr  input  16  master 0 address, stable while strobe high.
- M0BusIn  input  16  master 0 write data.
- M0BusOut  output  16  read data for master 0; valid when M0Done=1.
- M0Done  output  1  one-cycle completion pulse.
- M1ReadData, M1WriteData, M1Addr, M1BusIn, M1BusOut, M1Done: same as the M0 ports, for master 1.
- ReadData, WriteData  output  1 each  strobes to the bus.
- DataAddr  output  16  address to the bus.
- BusIn  output  16  write data to the bus.
- BusOut  input  16  read data from the bus.
- DataDone  input  1  bus completion (may be combinational or registered).
- ArbErr  output  1  one-cycle pulse on timeout abort.

## Operation
- States:
  - IDLE: no strobes, DataAddr=0, BusIn=0.
  - GRANT0 / GRANT1: forward the granted master's signals.
  - RESP: strobes low, pulse the granted master's Done.
- IDLE arbitration:
  - A request is Mn(ReadData|WriteData).
  - Only one master requesting: grant it.
  - Both requesting: grant the master not in `last_grant`.
  - Set `last_grant` to the granted master and go to GRANTn.
- GRANTn:
  - ReadData = MnReadData & ~MnWriteData. Write wins if both strobes are high.
  - WriteData = MnWriteData, DataAddr = MnAddr, BusIn = MnBusIn.
  - On DataDone=1, latch BusOut into `rdata` and go to RESP.
  - If master n drops both strobes while in GRANTn (protocol violation): go to IDLE, no Done.
- RESP:
  - MnDone=1 for the granted master only; MnBusOut=`rdata`. The other Done stays 0.
  - Next state is always IDLE.
  - The single RESP cycle with strobes low guarantees that the memory's toggling done flag returns to 0 before the next transaction.
- MnBusOut holds `rdata` in every state. For writes the value is don't-care but deterministic: it is the latched BusOut.
- A master that keeps its strobe high after Done is treated as a new request in the following IDLE cycle and arbitrated normally.
- Reset:
  - State goes to IDLE, `last_grant`=1 (so master 0 wins the first tie), `rdata`=0, timeout counter=0.
  - All outputs 0: strobes, DataAddr, BusIn, M0Done, M1Done, M0BusOut, M1BusOut, ArbErr.
  - Reset mid-GRANT abandons the transaction with no Done pulse. Strobes fall at the reset edge.

## Timing
- Strobes and Done are decoded from registered state. There are no combinational paths from master inputs to Done.
- Combinational forwarding paths: MnAddr/MnBusIn/strobes to the bus outputs while in GRANTn.
- Latency, request seen in IDLE to MnDone:
  - 1 (IDLE) + k (GRANT cycles until DataDone) + 1 (RESP).
  - IO device (DataDone combinational): 3 cycles.
  - Memory (done registered): 4 cycles.
- Throughput: one transaction per k+2 cycles.
- Under continuous contention the grant strictly alternates between the masters. A waiting master is served within one foreign transaction.

## Configuration
- Macro `DATA_BUS_ARB_TIMEOUT_EN`.
- Defined:
  - A counter clears on entry to GRANTn and increments each GRANT cycle.
  - If it reaches TIMEOUT_CYCLES with no DataDone: latch `rdata`=16'hDEAD, pulse ArbErr together with the RESP cycle, then proceed as a normal RESP.
- Undefined:
  - No counter; GRANT waits indefinitely.
  - ArbErr tied 0.

## Test plan
- Reset, then M0 reads IO switches (addr 16'h2100, SW=10'h2A5) -> M0Done in cycle 3, M0BusOut=16'h02A5, M1Done=0.
- M1 writes 16'h1234 to memory addr 16'h0010, then M1 reads it back -> WriteData high with DataAddr=16'h0010 during GRANT1, then a read returns 16'h1234 with Done 4 cycles after the request.
- Both masters request reads every cycle for 8 transactions after reset -> grants run M0, M1, M0, M1...; no Done pulses twice in a row for the same master.
- M0 asserts ReadData and WriteData together with M0BusIn=16'h0055 to LEDR (16'h2200) -> ReadData=0, WriteData=1, LEDR=10'h055.
- Reset asserted during GRANT0 of a memory read -> next cycle state is IDLE, all strobes 0, no M0Done, then the first tie goes to M0.
- With `DATA_BUS_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=4, and bus DataDone forced 0 -> after 4 GRANT cycles, ArbErr=1 and M0Done=1 in the same cycle, M0BusOut=16'hDEAD.
